// File: rtl/thread_sched.sv
// thread_sched: round-robin fetch-thread scheduler for a 4-thread barrel pipeline.
// Each rising edge (unless stalled) it picks the next enabled thread whose
// reissue cooldown has expired, searching from the thread after the one most
// recently issued. It presents the pick in the IF stage and the previous pick
// in the ID stage.
//
// Ports:
//   clk        - clock, all state changes on the rising edge
//   rst        - asynchronous active-low reset
//   thread_en  - per-thread enable mask (bit n = thread n schedulable)
//   stall      - freezes every register while 1
//   thread_IF  - thread selected for fetch (registered)
//   valid_IF   - thread_IF is a real issue; 0 = bubble
//   thread_ID  - thread_IF delayed one stage
//   valid_ID   - valid_IF delayed one stage
//   issue_cnt  - free-running count of valid issues since reset (wraps)
module thread_sched #(
  parameter int unsigned REISSUE_GAP = 4  // min cycles between issues of one thread, 1..7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  thread_en,
  input  logic        stall,
  output logic [1:0]  thread_IF,
  output logic        valid_IF,
  output logic [1:0]  thread_ID,
  output logic        valid_ID,
  output logic [15:0] issue_cnt
);

  // A freshly issued thread waits REISSUE_GAP-1 further edges before it is eligible again.
  localparam logic [2:0] RELOAD = 3'(REISSUE_GAP - 1);

  logic [1:0] last;
  logic [2:0] cooldown [4];
  logic       found;
  logic [1:0] cand;

  // Search order last+1, last+2, last+3, last (2-bit add wraps mod 4).
  always_comb begin
    found = 1'b0;
    cand  = last;
    for (int unsigned i = 1; i <= 4; i++) begin
      if (!found && thread_en[last + 2'(i)] && (cooldown[last + 2'(i)] == '0)) begin
        found = 1'b1;
        cand  = last + 2'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      thread_IF <= '0;
      valid_IF  <= 1'b0;
      thread_ID <= '0;
      valid_ID  <= 1'b0;
      issue_cnt <= '0;
      last      <= 2'd3;
      for (int unsigned n = 0; n < 4; n++) begin
        cooldown[n] <= '0;
      end
    end else if (!stall) begin
      valid_IF  <= found;
      thread_ID <= thread_IF;
      valid_ID  <= valid_IF;
      if (found) begin
        thread_IF <= cand;
        last      <= cand;
        issue_cnt <= issue_cnt + 16'd1;
      end
      for (int unsigned n = 0; n < 4; n++) begin
        if (found && (cand == 2'(n))) begin
          cooldown[n] <= RELOAD;
        end else if (cooldown[n] != '0) begin
          cooldown[n] <= cooldown[n] - 3'd1;
        end
      end
    end
  end

endmodule
